// File: rtl/ffas.sv
// Modular adder over GF(2^255 - 19): out = (a + b) mod p.
// One 64-bit limb adder and one limb subtractor run skewed by a limb; done pulses 6 cycles after accept.
module ffas (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic [255:0] out,
  output logic         done,
  output logic         busy
);

  localparam int unsigned W     = 256;
  localparam int unsigned LIMB  = 64;
  localparam int unsigned NLIMB = W / LIMB;
  localparam int unsigned IDXW  = 2;

  localparam logic [W-1:0] P = {1'b1, 255'b0} - 256'd19;
  localparam logic [NLIMB-1:0][LIMB-1:0] P_L = P;

  typedef enum logic [2:0] {
    IDLE,
    ADD0,
    ADD1,
    ADD2,
    ADD3,
    SUB3,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [NLIMB-1:0][LIMB-1:0] a_q, b_q, sum_q, diff_q;
  logic                       carry_q, borrow_q;

  logic            busy_d, done_d;
  logic            load, add_en, sub_en, fin;
  logic [IDXW-1:0] add_idx, sub_idx;
  logic [LIMB:0]   add_res, sub_res;

  // Sequencing: adder walks limbs 0..3, subtractor trails it by one limb.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    add_en  = 1'b0;
    sub_en  = 1'b0;
    fin     = 1'b0;
    add_idx = '0;
    sub_idx = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ADD0;
        end
      end
      ADD0: begin
        add_en  = 1'b1;
        add_idx = 2'd0;
        state_d = ADD1;
      end
      ADD1: begin
        add_en  = 1'b1;
        add_idx = 2'd1;
        sub_en  = 1'b1;
        sub_idx = 2'd0;
        state_d = ADD2;
      end
      ADD2: begin
        add_en  = 1'b1;
        add_idx = 2'd2;
        sub_en  = 1'b1;
        sub_idx = 2'd1;
        state_d = ADD3;
      end
      ADD3: begin
        add_en  = 1'b1;
        add_idx = 2'd3;
        sub_en  = 1'b1;
        sub_idx = 2'd2;
        state_d = SUB3;
      end
      SUB3: begin
        sub_en  = 1'b1;
        sub_idx = 2'd3;
        state_d = FIN;
      end
      FIN: begin
        fin     = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign add_res = {1'b0, a_q[add_idx]} + {1'b0, b_q[add_idx]} + (LIMB+1)'(carry_q);
  assign sub_res = {1'b0, sum_q[sub_idx]} - {1'b0, P_L[sub_idx]} - (LIMB+1)'(borrow_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      diff_q   <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      out      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      if (load) begin
        a_q      <= a;
        b_q      <= b;
        carry_q  <= 1'b0;
        borrow_q <= 1'b0;
      end
      if (add_en) begin
        sum_q[add_idx] <= add_res[LIMB-1:0];
        carry_q        <= add_res[LIMB];
      end
      if (sub_en) begin
        diff_q[sub_idx] <= sub_res[LIMB-1:0];
        borrow_q        <= sub_res[LIMB];
      end
      // a + b >= p exactly when the sum overflowed 256 bits or s - p did not borrow
      if (fin) begin
        out <= (carry_q || !borrow_q) ? diff_q : sum_q;
      end
    end
  end

endmodule

// File: tb/tb_ffas.sv
// Scoreboard bench for ffas: expected sums queued at accept, compared when done pulses.
module tb_ffas;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [255:0] a = '0;
  logic [255:0] b = '0;
  logic [255:0] out;
  logic         done;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] exp_q[$];
  logic [255:0] P;
  logic [255:0] ONES;

  ffas dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .out  (out),
    .done (done),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model(input logic [255:0] x, input logic [255:0] y);
    logic [256:0] s;
    logic [256:0] pw;
    s  = {1'b0, x} + {1'b0, y};
    pw = {1'b0, P};
    if (s >= pw) return 256'(s - pw);
    return s[255:0];
  endfunction

  // Result monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 256'(done), 256'd0);
      end else begin
        check("result", out, exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [255:0] x, input logic [255:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~x;
    b     = ~y;
    check("busy_accept", 256'(busy), 256'd1);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) check("busy_k5", 256'(busy), 256'd1);
      if (done) check("done_early", 256'(done), 256'd0);
    end
    @(posedge clk);
    #1;
    check("done_k6", 256'(done), 256'd1);
    check("busy_k6", 256'(busy), 256'd0);
    @(posedge clk);
    #1;
    check("done_k7", 256'(done), 256'd0);
  endtask

  initial begin
    P    = {1'b1, 255'b0} - 256'd19;
    ONES = '1;

    repeat (2) @(negedge clk);
    check("rst_out", out, 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    rst = 1'b1;

    do_op(256'd1, 256'd2);
    do_op((256'd1 << 64) - 256'd1, 256'd1);
    do_op((256'd1 << 192) - 256'd1, 256'd1);
    do_op(P - 256'd1, 256'd1);
    do_op(P - 256'd2, 256'd1);
    do_op(P - 256'd1, P - 256'd1);
    do_op(ONES, ONES);
    do_op(256'd0, 256'd0);
    for (int i = 0; i < 4; i++) begin
      do_op({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} % P,
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} % P);
    end
    repeat (3) @(posedge clk);
    check("model_top_carry", model(ONES, ONES), (256'd1 << 255) + 256'd17);

    // start held high: operands change after accept, second accept at k+7
    @(negedge clk);
    a     = 256'h1234_5678_9abc_def0;
    b     = P - 256'd5;
    start = 1'b1;
    exp_q.push_back(model(256'h1234_5678_9abc_def0, P - 256'd5));
    @(posedge clk);
    #1;
    check("hold_busy_k", 256'(busy), 256'd1);
    a = ONES;
    b = (256'd1 << 128) + 256'd77;
    exp_q.push_back(model(ONES, (256'd1 << 128) + 256'd77));
    repeat (6) @(posedge clk);
    #1;
    check("hold_done_k6", 256'(done), 256'd1);
    check("hold_busy_k6", 256'(busy), 256'd0);
    @(posedge clk);
    #1;
    check("hold_accept_k7", 256'(busy), 256'd1);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("hold_done_k13", 256'(done), 256'd1);
    repeat (2) @(posedge clk);

    // reset mid-operation: no result is queued, so any done is flagged
    @(negedge clk);
    a     = 256'd100;
    b     = 256'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_out", out, 256'd0);
    check("abort_busy", 256'(busy), 256'd0);
    check("abort_done", 256'(done), 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_idle_busy", 256'(busy), 256'd0);

    do_op(256'd40, 256'd2);
    repeat (3) @(posedge clk);
    check("queue_empty", 256'(exp_q.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
